// File: rtl/codec_capture_conditioner_if.sv
// Signal bundle between the AC97 record path, the capture conditioner and its 100 MHz consumer.
// The slave modport is the conditioner's view; the master modport is the codec/consumer side.
interface codec_capture_conditioner_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic                     new_frame;
    logic [15:0]              adc_sample;
    logic [15:0]              sample_out;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     frame_tick;
    logic [$clog2(DEPTH):0]   fill_level;
    logic                     overflow;
    logic [CNT_W-1:0]         drop_count;
    logic                     overflow_clear;

    modport slave (
        input  new_frame, adc_sample, sample_ready, overflow_clear,
        output sample_out, sample_valid, frame_tick, fill_level, overflow, drop_count
    );

    modport master (
        output new_frame, adc_sample, sample_ready, overflow_clear,
        input  sample_out, sample_valid, frame_tick, fill_level, overflow, drop_count
    );
endinterface

// File: rtl/codec_capture_conditioner.sv
// Captures one AC97 ADC sample per new_frame after a fixed settling delay and buffers it in a
// first-word-fall-through FIFO with valid/ready output and sticky drop accounting.
module codec_capture_conditioner #(
    parameter int DEPTH         = 4,
    parameter int CAPTURE_DELAY = 2,
    parameter int CNT_W         = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    codec_capture_conditioner_if.slave  bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [7:0] DELAY_M1 = 8'((CAPTURE_DELAY > 0) ? CAPTURE_DELAY - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_HOLD} state_t;

    state_t           r_state, w_state_next;
    logic [7:0]       r_cnt, w_cnt_next;
    logic             r_prev_nf;
    logic [15:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    logic w_rise, w_push, w_pop, w_full, w_write, w_drop;

    assign w_rise = bus.new_frame & ~r_prev_nf;

    // The counter is loaded with DELAY-1 so that CAPTURE lands exactly DELAY cycles after the rise.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    if (CAPTURE_DELAY == 0) begin
                        w_push       = 1'b1;
                        w_state_next = S_HOLD;
                    end else if (CAPTURE_DELAY == 1) begin
                        w_state_next = S_CAPTURE;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = DELAY_M1;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.new_frame)       w_state_next = S_IDLE;
                else if (r_cnt == 8'd1)   w_state_next = S_CAPTURE;
                else                      w_cnt_next   = r_cnt - 8'd1;
            end
            S_CAPTURE: begin
                w_push       = 1'b1;
                w_state_next = bus.new_frame ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!bus.new_frame) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = (r_count != '0) & bus.sample_ready;
    assign w_write = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_prev_nf    <= 1'b1;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_prev_nf <= bus.new_frame;
            if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (bus.overflow_clear) begin
                r_overflow   <= w_drop;
                r_drop_count <= CNT_W'(w_drop);
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    // NOTE: the sample array is deliberately not reset; pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr] <= bus.adc_sample;
    end

    assign bus.sample_out   = (r_count != '0) ? r_mem[r_rd_ptr] : 16'h0000;
    assign bus.sample_valid = (r_count != '0);
    assign bus.frame_tick   = w_push;
    assign bus.fill_level   = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.drop_count   = r_drop_count;
endmodule

// File: tb/tb_codec_capture_conditioner.sv
// Randomized and directed bench for codec_capture_conditioner, scored against a frame-timeline
// and queue model of the capture path.
module tb_codec_capture_conditioner;
    localparam int DEPTH         = 4;
    localparam int CAPTURE_DELAY = 2;
    localparam int CNT_W         = 8;
    localparam int DROP_MAX      = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    codec_capture_conditioner_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    codec_capture_conditioner #(
        .DEPTH(DEPTH), .CAPTURE_DELAY(CAPTURE_DELAY), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending capture timeline, FIFO contents as a queue, drop accounting.
    logic [15:0] m_q[$];
    logic        m_prev_nf;
    logic        m_pending;
    int          m_rise_t;
    int          m_t;
    logic        m_ov;
    int          m_dc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @t=%0d: got %0h, expected %0h", tag, m_t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev_nf = 1'b1;
        m_pending = 1'b0;
        m_ov      = 1'b0;
        m_dc      = 0;
    endtask

    // Score the outputs for the current cycle, then advance the model across the coming edge.
    task automatic eval_cycle();
        logic cap, pop, drop;
        cap = 1'b0;
        if (m_pending && (m_t != m_rise_t + CAPTURE_DELAY) && !bus.new_frame) m_pending = 1'b0;
        if (!m_pending && bus.new_frame && !m_prev_nf) begin
            m_pending = 1'b1;
            m_rise_t  = m_t;
        end
        if (m_pending && (m_t == m_rise_t + CAPTURE_DELAY)) begin
            cap       = 1'b1;
            m_pending = 1'b0;
        end

        check("frame_tick",   32'(bus.frame_tick),   32'(cap));
        check("sample_valid", 32'(bus.sample_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("sample_out", 32'(bus.sample_out), 32'(m_q[0]));
        check("fill_level",   32'(bus.fill_level),   32'(m_q.size()));
        check("overflow",     32'(bus.overflow),     32'(m_ov));
        check("drop_count",   32'(bus.drop_count),   32'(m_dc));

        pop  = (m_q.size() != 0) && bus.sample_ready;
        drop = cap && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (cap && !drop) m_q.push_back(bus.adc_sample);
        if (bus.overflow_clear) begin
            m_ov = drop;
            m_dc = drop ? 1 : 0;
        end else if (drop) begin
            m_ov = 1'b1;
            if (m_dc < DROP_MAX) m_dc++;
        end
        m_prev_nf = bus.new_frame;
        m_t++;
    endtask

    task automatic run_cycle(input logic nf, input logic [15:0] smp, input logic rdy, input logic clr);
        @(negedge clk);
        bus.new_frame      = nf;
        bus.adc_sample     = smp;
        bus.sample_ready   = rdy;
        bus.overflow_clear = clr;
        #1;
        eval_cycle();
    endtask

    // One full frame: low, rise, wait, capture, hold. Ready/clear only asserted in the capture cycle.
    task automatic frame(input logic [15:0] smp, input logic rdy_cap, input logic clr_cap);
        run_cycle(1'b0, smp, 1'b0, 1'b0);
        run_cycle(1'b1, smp, 1'b0, 1'b0);
        run_cycle(1'b1, smp, 1'b0, 1'b0);
        run_cycle(1'b1, smp, rdy_cap, clr_cap);
        run_cycle(1'b1, smp, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) run_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, held over two edges, released with new_frame = nf.
    task automatic apply_reset(input logic nf);
        @(negedge clk);
        bus.new_frame      = nf;
        bus.sample_ready   = 1'b0;
        bus.overflow_clear = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_sample_out",   32'(bus.sample_out),   32'h0);
        check("rst_sample_valid", 32'(bus.sample_valid), 32'h0);
        check("rst_frame_tick",   32'(bus.frame_tick),   32'h0);
        check("rst_fill_level",   32'(bus.fill_level),   32'h0);
        check("rst_overflow",     32'(bus.overflow),     32'h0);
        check("rst_drop_count",   32'(bus.drop_count),   32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        eval_cycle();
    endtask

    initial begin
        bus.new_frame      = 1'b0;
        bus.adc_sample     = 16'h0000;
        bus.sample_ready   = 1'b0;
        bus.overflow_clear = 1'b0;
        reset              = 1'b1;
        m_t                = 0;
        m_rise_t           = 0;
        model_reset();
        apply_reset(1'b0);

        // Single capture: tick two cycles after the rise, head visible the cycle after.
        frame(16'h1234, 1'b0, 1'b0);
        drain();

        // Fill to DEPTH, drop a fifth, then read back in order.
        for (int i = 1; i <= 5; i++) frame(16'hA000 + 16'(i), 1'b0, 1'b0);
        drain();

        // Full FIFO with a pop in the capture cycle: accepted, sample ends up last.
        for (int i = 1; i <= 4; i++) frame(16'hB000 + 16'(i), 1'b0, 1'b0);
        frame(16'hB005, 1'b1, 1'b0);
        drain();

        // Saturate drop_count, then clear coinciding with a drop, then a plain clear.
        for (int i = 1; i <= 4; i++) frame(16'hC000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < DROP_MAX + 3; i++) frame(16'(i), 1'b0, 1'b0);
        frame(16'hCCCC, 1'b0, 1'b1);
        run_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        drain();

        // One-cycle new_frame pulse is abandoned in the wait window.
        run_cycle(1'b0, 16'hDEAD, 1'b0, 1'b0);
        run_cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        repeat (4) run_cycle(1'b0, 16'hDEAD, 1'b0, 1'b0);

        // Reset during the wait window with two entries held and new_frame high across release.
        frame(16'hE001, 1'b0, 1'b0);
        frame(16'hE002, 1'b0, 1'b0);
        run_cycle(1'b0, 16'hE003, 1'b0, 1'b0);
        run_cycle(1'b1, 16'hE003, 1'b0, 1'b0);
        apply_reset(1'b1);
        repeat (5) run_cycle(1'b1, 16'hE004, 1'b0, 1'b0);
        frame(16'hE005, 1'b0, 1'b0);
        drain();

        // Random frames of varying length with random consumer back-pressure and clears.
        for (int f = 0; f < 300; f++) begin
            logic [15:0] smp;
            int lo_len, hi_len;
            smp    = 16'($urandom);
            lo_len = $urandom_range(1, 4);
            hi_len = $urandom_range(1, 6);
            for (int c = 0; c < lo_len; c++)
                run_cycle(1'b0, 16'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
            for (int c = 0; c < hi_len; c++)
                run_cycle(1'b1, smp, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
